// File: rtl/sram_controller.sv
// Purpose: serves MEM-stage load/store requests from a 16-bit async SRAM as two halfword accesses.
// Latency: ready stays low for 2*WAIT_CYCLES+1 cycles per access; readdata is valid in the DONE cycle.
// Backpressure: ready=0 while an access is in flight; request inputs must stay stable until ready=1.
module sram_controller #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        address,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t               state;
  state_t               state_nx;
  logic [3:0]           cnt;
  logic                 op_wr;
  logic [SRAM_AW-2:0]   widx_reg;
  logic [15:0]          wdata_hi;
  logic [15:0]          lo_reg;
  logic [31:0]          addr_off;
  logic                 req;
  logic                 last;
  logic                 in_acc;
  logic                 unused_addr_bits;

  assign addr_off = address - BASE_ADDR;
  assign req      = read | write;
  assign last     = (cnt == CNT_LAST);
  assign in_acc   = (state == LO) || (state == HI);

  // Word index only uses the bits that fit in the SRAM; the rest is truncated.
  assign unused_addr_bits = ^{addr_off[31:SRAM_AW+1], addr_off[1:0]};

  // Next-state logic: two timed halfword phases, then a single ready cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req)  state_nx = LO;
      LO:      if (last) state_nx = HI;
      HI:      if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Phase timer: restarts on every state entry, counts while a phase is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (state_nx != state) cnt <= '0;
    else if (in_acc)            cnt <= cnt + 4'd1;
  end

  // Request capture and halfword sequencing of address / write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr       <= 1'b0;
      widx_reg    <= '0;
      wdata_hi    <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else if (state == IDLE && req) begin
      // write wins when both are requested
      op_wr     <= write;
      widx_reg  <= addr_off[SRAM_AW:2];
      wdata_hi  <= writedata[31:16];
      sram_addr <= {addr_off[SRAM_AW:2], 1'b0};
      if (write) sram_dq_out <= writedata[15:0];
    end else if (state == LO && last) begin
      sram_addr <= {widx_reg, 1'b1};
      if (op_wr) sram_dq_out <= wdata_hi;
    end
  end

  // Read data capture: low half at end of LO, full word assembled at end of HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_reg   <= '0;
      readdata <= '0;
    end else if (!op_wr && last) begin
      if (state == LO) lo_reg   <= sram_dq_in;
      if (state == HI) readdata <= {sram_dq_in, lo_reg};
    end
  end

  // Strobes are decoded from state so reset releases them without a clock.
  always_comb begin
    sram_ce_n  = ~in_acc;
    sram_we_n  = ~(in_acc & op_wr);
    sram_oe_n  = ~(in_acc & ~op_wr);
    sram_dq_oe = in_acc & op_wr;
    ready      = ((state == IDLE) & ~req) | (state == DONE);
  end

endmodule

// File: tb/tb_sram_controller.sv
// Purpose: directed checks of sram_controller against a behavioural 16-bit SRAM.
// Latency: expects 7 ready-low cycles per access with WAIT_CYCLES=3.
// Backpressure: holds request inputs stable until ready is seen high.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  sram_controller #(
    .WAIT_CYCLES(3),
    .BASE_ADDR  (32'd1024),
    .SRAM_AW    (18)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );

  // Behavioural SRAM: a write only lands after a full 3-cycle phase at a stable address.
  logic [15:0] mem [0:63];
  logic        filled = 1'b0;
  int          run = 0;
  logic [17:0] last_a = '0;

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!filled) begin
      for (int k = 0; k < 64; k++) mem[k] = 16'hA5A5;
      filled = 1'b1;
    end
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (run > 0 && sram_addr == last_a) run = run + 1;
      else run = 1;
      last_a = sram_addr;
      if (run == 3) mem[sram_addr[5:0]] = sram_dq_out;
    end else begin
      run = 0;
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int low, output logic [7:0] oe_pat, output logic [7:0] we_pat,
                        output logic [31:0] rdata);
    @(negedge clk);
    read = rd; write = wr; address = a; writedata = d;
    low = 0; oe_pat = 8'hFF; we_pat = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (i < 8) begin
        oe_pat[i] = sram_oe_n;
        we_pat[i] = sram_we_n;
      end
      if (ready) break;
      low++;
      @(negedge clk);
    end
    rdata = readdata;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    #3;
    vec++; if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b expected 1", ready); end
    vec++; if (readdata !== 32'h0) begin errs++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
    vec++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      errs++; $display("FAIL reset_strobes: got %b expected 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}); end
    vec++; if (sram_addr !== 18'h0) begin errs++; $display("FAIL reset_addr: got %h expected 0", sram_addr); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write;
    int low; logic [7:0] oe_p, we_p; logic [31:0] rd;
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, low, oe_p, we_p, rd);
    vec++; if (low !== 7) begin errs++; $display("FAIL write_ready_low: got %0d expected 7", low); end
    vec++; if (we_p !== 8'h81) begin errs++; $display("FAIL write_we_pattern: got %h expected 81", we_p); end
    vec++; if (oe_p !== 8'hFF) begin errs++; $display("FAIL write_oe_pattern: got %h expected ff", oe_p); end
    vec++; if (mem[2] !== 16'hBEEF) begin errs++; $display("FAIL write_mem2: got %h expected beef", mem[2]); end
    vec++; if (mem[3] !== 16'hDEAD) begin errs++; $display("FAIL write_mem3: got %h expected dead", mem[3]); end
  endtask

  task automatic test_read;
    int low; logic [7:0] oe_p, we_p; logic [31:0] rd;
    access(1'b1, 1'b0, 32'd1028, 32'h0, low, oe_p, we_p, rd);
    vec++; if (low !== 7) begin errs++; $display("FAIL read_ready_low: got %0d expected 7", low); end
    vec++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL read_data: got %h expected deadbeef", rd); end
    vec++; if (oe_p !== 8'h81) begin errs++; $display("FAIL read_oe_pattern: got %h expected 81", oe_p); end
    vec++; if (we_p !== 8'hFF) begin errs++; $display("FAIL read_we_pattern: got %h expected ff", we_p); end
  endtask

  task automatic test_rw_both;
    int low; logic [7:0] oe_p, we_p; logic [31:0] rd;
    access(1'b1, 1'b1, 32'd1024, 32'h12345678, low, oe_p, we_p, rd);
    vec++; if (low !== 7) begin errs++; $display("FAIL both_ready_low: got %0d expected 7", low); end
    vec++; if (we_p !== 8'h81) begin errs++; $display("FAIL both_we_pattern: got %h expected 81", we_p); end
    vec++; if (mem[0] !== 16'h5678) begin errs++; $display("FAIL both_mem0: got %h expected 5678", mem[0]); end
    vec++; if (mem[1] !== 16'h1234) begin errs++; $display("FAIL both_mem1: got %h expected 1234", mem[1]); end
    vec++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL both_readdata_kept: got %h expected deadbeef", rd); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] pat; logic [31:0] rd1, rd2;
    pat = '0; rd1 = '0; rd2 = '0;
    @(negedge clk);
    read = 1'b1; address = 32'd1028;
    for (int i = 0; i < 16; i++) begin
      #1;
      pat[i] = ready;
      if (i == 7)  rd1 = readdata;
      if (i == 15) rd2 = readdata;
      @(negedge clk);
      if (i == 7) address = 32'd1024;
    end
    read = 1'b0;
    vec++; if (pat !== 16'h8080) begin errs++; $display("FAIL b2b_ready_pattern: got %h expected 8080", pat); end
    vec++; if (rd1 !== 32'hDEADBEEF) begin errs++; $display("FAIL b2b_first_data: got %h expected deadbeef", rd1); end
    vec++; if (rd2 !== 32'h12345678) begin errs++; $display("FAIL b2b_second_data: got %h expected 12345678", rd2); end
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk);
    read = 1'b1; address = 32'd1028;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1; read = 1'b0;
    #1;
    vec++; if (readdata !== 32'h0) begin errs++; $display("FAIL rst_rd_readdata: got %h expected 0", readdata); end
    vec++; if (ready !== 1'b1) begin errs++; $display("FAIL rst_rd_ready: got %b expected 1", ready); end
    vec++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      errs++; $display("FAIL rst_rd_strobes: got %b expected 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    int low; logic [7:0] oe_p, we_p; logic [31:0] rd;
    @(negedge clk);
    write = 1'b1; address = 32'd1032; writedata = 32'hCAFEF00D;
    repeat (4) @(negedge clk);
    #1;
    vec++; if ({sram_addr, sram_we_n} !== {18'd5, 1'b0}) begin
      errs++; $display("FAIL rst_wr_hi_phase: got addr %0d we_n %b expected addr 5 we_n 0", sram_addr, sram_we_n); end
    #1;
    rst = 1'b1; write = 1'b0;
    #1;
    vec++; if (mem[4] !== 16'hF00D) begin errs++; $display("FAIL rst_wr_mem4: got %h expected f00d", mem[4]); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    vec++; if (mem[5] !== 16'hA5A5) begin errs++; $display("FAIL rst_wr_mem5: got %h expected a5a5", mem[5]); end
    #1;
    vec++; if (ready !== 1'b1) begin errs++; $display("FAIL rst_wr_idle_ready: got %b expected 1", ready); end
    vec++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      errs++; $display("FAIL rst_wr_strobes: got %b expected 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}); end
    access(1'b1, 1'b0, 32'd1032, 32'h0, low, oe_p, we_p, rd);
    vec++; if (low !== 7) begin errs++; $display("FAIL rst_wr_readback_low: got %0d expected 7", low); end
    vec++; if (rd !== 32'hA5A5F00D) begin errs++; $display("FAIL rst_wr_readback: got %h expected a5a5f00d", rd); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_rw_both;
    test_back_to_back;
    test_reset_mid_read;
    test_reset_mid_write;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
